// File: rtl/pc_branch_pkg.sv
// pc_branch_pkg: shared types and reset constants for the PC / branch-target unit.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
// Contents: FSM state enum, next-PC select enum, branch-table reset values.
package pc_branch_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } pc_state_t;

  typedef enum logic [2:0] {
    SEL_START,
    SEL_HOLD,
    SEL_JUMP,
    SEL_BRANCH,
    SEL_INC
  } pc_sel_t;

  // Power-on contents of the branch-target table (two's-complement offsets).
  localparam int TBL_RST_E0 = -5;
  localparam int TBL_RST_E1 = 20;
  localparam int TBL_RST_E2 = -1;

  // Reset value of table entry idx; entries past the defaults are zero.
  function automatic int tbl_reset_value(input int idx);
    case (idx)
      0:       return TBL_RST_E0;
      1:       return TBL_RST_E1;
      2:       return TBL_RST_E2;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/pc_branch_unit_if.sv
// pc_branch_unit_if: control, table-write and status bundle of the PC / branch unit.
// Latency: n/a (wires only).
// Backpressure: none; every control is a single-cycle strobe sampled on the clock edge.
// master: drives start/halt/jump/branch/taken/lut_addr/wr_*, observes pc/target/halted/fault.
// slave : the PC unit itself.
interface pc_branch_unit_if #(
  parameter int D  = 12,
  parameter int LA = 2
);
  logic          start;
  logic          halt;
  logic          jump;
  logic          branch;
  logic          taken;
  logic [LA-1:0] lut_addr;
  logic          wr_en;
  logic [LA-1:0] wr_addr;
  logic [D-1:0]  wr_data;
  logic [D-1:0]  pc;
  logic [D-1:0]  target;
  logic          halted;
  logic          fault;

  modport master (
    output start, halt, jump, branch, taken, lut_addr, wr_en, wr_addr, wr_data,
    input  pc, target, halted, fault
  );

  modport slave (
    input  start, halt, jump, branch, taken, lut_addr, wr_en, wr_addr, wr_data,
    output pc, target, halted, fault
  );
endinterface

// File: rtl/pc_target_table.sv
// pc_target_table: 2**LA x D branch-target register file, one write port, one async read port.
// Latency: write lands at the clock edge; read is combinational from the registers.
// Backpressure: none; writes are accepted every cycle in every FSM state.
// Ports: Clk, Reset (async, active-high), i_wr_en/i_wr_addr/i_wr_data, i_rd_addr -> o_rd_data.
module pc_target_table
  import pc_branch_pkg::*;
#(
  parameter int D  = 12,
  parameter int LA = 2
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          i_wr_en,
  input  logic [LA-1:0] i_wr_addr,
  input  logic [D-1:0]  i_wr_data,
  input  logic [LA-1:0] i_rd_addr,
  output logic [D-1:0]  o_rd_data
);

  localparam int N = 2 ** LA;

  logic [D-1:0] r_tbl [N];

  // Reset has priority over a write presented in the same cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < N; i++) begin
        r_tbl[i] <= D'(tbl_reset_value(i));
      end
    end else if (i_wr_en) begin
      r_tbl[i_wr_addr] <= i_wr_data;
    end
  end

  // Combinational read: a same-cycle write is seen only after the edge.
  assign o_rd_data = r_tbl[i_rd_addr];

endmodule

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: fetch-stage program counter with a writable branch-target table and RUN/HALT FSM.
// Latency: controls sampled at edge N, new pc visible after edge N; target is combinational.
// Backpressure: none; halt (or a bounds fault) freezes the PC until start.
// Ports: Clk, Reset (async, active-high), bus (pc_branch_unit_if.slave).
// Optional feature: define PC_BOUNDS_EN to hold the PC, raise sticky fault and HALT
// whenever the computed next PC reaches PROG_DEPTH.
module pc_branch_unit
  import pc_branch_pkg::*;
#(
  parameter int           D          = 12,
  parameter int           LA         = 2,
  parameter logic [D-1:0] START_PC   = '0,
  parameter int           PROG_DEPTH = 2 ** D
) (
  input  logic             Clk,
  input  logic             Reset,
  pc_branch_unit_if.slave  bus
);

  // PROG_DEPTH must be a reachable-or-just-past-the-end address.
  if (PROG_DEPTH < 1 || PROG_DEPTH > 2 ** D) begin : g_bad_prog_depth
    $error("pc_branch_unit: PROG_DEPTH out of range");
  end

  pc_state_t    r_state;
  pc_state_t    w_state_nxt;
  pc_sel_t      w_sel;
  logic [D-1:0] r_pc;
  logic [D-1:0] w_target;
  logic [D-1:0] w_calc_pc;
  logic [D-1:0] w_pc_nxt;
  logic         w_bound_hit;
  logic         w_halted;

  pc_target_table #(
    .D  (D),
    .LA (LA)
  ) u_table (
    .Clk       (Clk),
    .Reset     (Reset),
    .i_wr_en   (bus.wr_en),
    .i_wr_addr (bus.wr_addr),
    .i_wr_data (bus.wr_data),
    .i_rd_addr (bus.lut_addr),
    .o_rd_data (w_target)
  );

  // Next-PC source, highest priority first. A branch with taken=0 falls to increment.
  always_comb begin
    w_sel = SEL_INC;
    if (bus.start) begin
      w_sel = SEL_START;
    end else if (bus.halt || r_state == HALT) begin
      w_sel = SEL_HOLD;
    end else if (bus.jump) begin
      w_sel = SEL_JUMP;
    end else if (bus.branch && bus.taken) begin
      w_sel = SEL_BRANCH;
    end
  end

  // Candidate PC for the advancing cases; all arithmetic wraps modulo 2**D.
  always_comb begin
    w_calc_pc = r_pc + D'(1);
    case (w_sel)
      SEL_JUMP:   w_calc_pc = w_target;
      SEL_BRANCH: w_calc_pc = r_pc + w_target;
      default:    w_calc_pc = r_pc + D'(1);
    endcase
  end

`ifdef PC_BOUNDS_EN
  localparam logic [D:0] PROG_LIMIT = (D+1)'(PROG_DEPTH);

  logic w_advance;
  logic r_fault;

  assign w_advance   = (w_sel == SEL_JUMP) || (w_sel == SEL_BRANCH) || (w_sel == SEL_INC);
  assign w_bound_hit = w_advance && ({1'b0, w_calc_pc} >= PROG_LIMIT);

  // Sticky until start or Reset; start wins over a same-cycle hit (start never advances).
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_fault <= 1'b0;
    end else if (bus.start) begin
      r_fault <= 1'b0;
    end else if (w_bound_hit) begin
      r_fault <= 1'b1;
    end
  end

  assign bus.fault = r_fault;
`else
  assign w_bound_hit = 1'b0;
  assign bus.fault   = 1'b0;
`endif

  always_comb begin
    w_pc_nxt = r_pc;
    case (w_sel)
      SEL_START: w_pc_nxt = START_PC;
      SEL_HOLD:  w_pc_nxt = r_pc;
      default:   w_pc_nxt = w_bound_hit ? r_pc : w_calc_pc;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_pc <= START_PC;
    end else begin
      r_pc <= w_pc_nxt;
    end
  end

  // FSM: state register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state. start always returns to RUN; HALT is otherwise absorbing.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.start) begin
      w_state_nxt = RUN;
    end else if (r_state == RUN && (bus.halt || w_bound_hit)) begin
      w_state_nxt = HALT;
    end
  end

  // FSM: outputs.
  always_comb begin
    w_halted = 1'b0;
    if (r_state == HALT) begin
      w_halted = 1'b1;
    end
  end

  assign bus.pc     = r_pc;
  assign bus.target = w_target;
  assign bus.halted = w_halted;

endmodule

// File: tb/tb_pc_branch_unit.sv
// tb_pc_branch_unit: directed self-checking bench for pc_branch_unit (D=12, LA=2).
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
// Build with PC_BOUNDS_EN defined to exercise the bounds-fault sequence (PROG_DEPTH=64).
module tb_pc_branch_unit;

`ifdef PC_BOUNDS_EN
  localparam int TB_DEPTH = 64;
`else
  localparam int TB_DEPTH = 4096;
`endif

  logic Clk;
  logic Reset;
  int   n_checks = 0;
  int   n_errors = 0;

  pc_branch_unit_if #(.D(12), .LA(2)) bus ();

  pc_branch_unit #(
    .D          (12),
    .LA         (2),
    .START_PC   (12'h000),
    .PROG_DEPTH (TB_DEPTH)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.start    = 1'b0;
    bus.halt     = 1'b0;
    bus.jump     = 1'b0;
    bus.branch   = 1'b0;
    bus.taken    = 1'b0;
    bus.lut_addr = 2'd0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = 2'd0;
    bus.wr_data  = 12'h000;
  endtask

  initial begin
    Reset = 1'b1;
    idle_inputs();
    bus.lut_addr = 2'd1;
    #12;
    check("reset_pc",     32'(bus.pc),     32'h000);
    check("reset_tgt1",   32'(bus.target), 32'h014);
    check("reset_halted", 32'(bus.halted), 32'h0);
    check("reset_fault",  32'(bus.fault),  32'h0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    check("pc_after_rel", 32'(bus.pc), 32'h000);

    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("idle_pc%0d", i), 32'(bus.pc), 32'(i));
    end
    check("idle_halted", 32'(bus.halted), 32'h0);

`ifndef PC_BOUNDS_EN
    // Relative branch by -5 from 4 wraps to 0xFFF.
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    check("start_pc", 32'(bus.pc), 32'h000);
    repeat (4) tick();
    bus.branch = 1'b1; bus.taken = 1'b1; bus.lut_addr = 2'd0;
    tick();
    check("br_neg5_wrap", 32'(bus.pc), 32'hFFF);
    idle_inputs();
    tick();
    check("inc_wrap", 32'(bus.pc), 32'h000);

    // Branch by -1 from 4.
    repeat (4) tick();
    check("pc4_again", 32'(bus.pc), 32'h004);
    bus.branch = 1'b1; bus.taken = 1'b1; bus.lut_addr = 2'd2;
    tick();
    check("br_neg1", 32'(bus.pc), 32'h003);
    idle_inputs();
    repeat (4) tick();
    check("pc7", 32'(bus.pc), 32'h007);

    // Untaken branch behaves as increment.
    bus.branch = 1'b1; bus.taken = 1'b0; bus.lut_addr = 2'd1;
    tick();
    check("br_not_taken", 32'(bus.pc), 32'h008);
    idle_inputs();

    // Same-cycle write and jump: old entry used, new value visible afterwards.
    bus.wr_en = 1'b1; bus.wr_addr = 2'd3; bus.wr_data = 12'h100;
    bus.jump = 1'b1; bus.lut_addr = 2'd3;
    #1;
    check("tgt_before_wr", 32'(bus.target), 32'h000);
    tick();
    bus.wr_en = 1'b0;
    check("jump_old_entry", 32'(bus.pc), 32'h000);
    check("tgt_after_wr", 32'(bus.target), 32'h100);
    tick();
    check("jump_new_entry", 32'(bus.pc), 32'h100);

    // Jump and taken branch together: jump wins.
    bus.jump = 1'b1; bus.branch = 1'b1; bus.taken = 1'b1; bus.lut_addr = 2'd1;
    tick();
    check("jump_over_br", 32'(bus.pc), 32'h014);
    idle_inputs();

    // HALT holds PC for several cycles, table still writable, start resumes.
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    repeat (9) tick();
    check("pc9", 32'(bus.pc), 32'h009);
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    check("halt_pc_c1", 32'(bus.pc), 32'h009);
    check("halt_hl_c1", 32'(bus.halted), 32'h1);
    bus.wr_en = 1'b1; bus.wr_addr = 2'd2; bus.wr_data = 12'h007; bus.lut_addr = 2'd2;
    tick();
    bus.wr_en = 1'b0;
    check("halt_pc_c2", 32'(bus.pc), 32'h009);
    check("halt_hl_c2", 32'(bus.halted), 32'h1);
    check("halt_wr_tgt", 32'(bus.target), 32'h007);
    bus.jump = 1'b1; bus.lut_addr = 2'd1;
    tick();
    bus.jump = 1'b0;
    check("halt_pc_c3", 32'(bus.pc), 32'h009);
    check("halt_hl_c3", 32'(bus.halted), 32'h1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("resume_pc", 32'(bus.pc), 32'h000);
    check("resume_hl", 32'(bus.halted), 32'h0);

    // Asynchronous reset mid-cycle, with a table write pending.
    bus.wr_en = 1'b1; bus.wr_addr = 2'd3; bus.wr_data = 12'h020;
    tick();
    bus.wr_en = 1'b0;
    bus.jump = 1'b1; bus.lut_addr = 2'd3;
    tick();
    idle_inputs();
    check("pc_0x20", 32'(bus.pc), 32'h020);
    bus.wr_en = 1'b1; bus.wr_addr = 2'd0; bus.wr_data = 12'h055;
    #3;
    Reset = 1'b1;
    #1;
    check("async_rst_pc", 32'(bus.pc), 32'h000);
    check("async_rst_tgt0", 32'(bus.target), 32'hFFB);
    tick();
    check("rst_blocks_wr", 32'(bus.target), 32'hFFB);
    check("rst_hold_pc", 32'(bus.pc), 32'h000);
    Reset = 1'b0;
    idle_inputs();
    tick();
    check("post_rst_inc", 32'(bus.pc), 32'h001);
`else
    // Bounds: PROG_DEPTH = 64.
    bus.wr_en = 1'b1; bus.wr_addr = 2'd3; bus.wr_data = 12'd80;
    tick();
    bus.wr_en = 1'b0;
    repeat (54) tick();
    check("pc60", 32'(bus.pc), 32'd60);
    check("pre_fault", 32'(bus.fault), 32'h0);
    bus.jump = 1'b1; bus.lut_addr = 2'd3;
    tick();
    bus.jump = 1'b0;
    check("oob_jump_pc", 32'(bus.pc), 32'd60);
    check("oob_fault", 32'(bus.fault), 32'h1);
    check("oob_halted", 32'(bus.halted), 32'h1);
    tick();
    check("fault_sticky", 32'(bus.fault), 32'h1);
    check("fault_hold_pc", 32'(bus.pc), 32'd60);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("clr_pc", 32'(bus.pc), 32'h000);
    check("clr_fault", 32'(bus.fault), 32'h0);
    check("clr_halted", 32'(bus.halted), 32'h0);
    // Increment past the last legal address.
    bus.wr_en = 1'b1; bus.wr_addr = 2'd3; bus.wr_data = 12'd63;
    tick();
    bus.wr_en = 1'b0;
    bus.jump = 1'b1; bus.lut_addr = 2'd3;
    tick();
    bus.jump = 1'b0;
    check("pc63", 32'(bus.pc), 32'd63);
    check("pc63_fault", 32'(bus.fault), 32'h0);
    tick();
    check("inc_oob_pc", 32'(bus.pc), 32'd63);
    check("inc_oob_fault", 32'(bus.fault), 32'h1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
